// File: rtl/ycbcr_pkg.sv
// Shared types and defaults for the OV7670 YCbCr 4:2:2 capture front end.
package ycbcr_pkg;

  typedef enum logic [1:0] {
    PH_CB = 2'd0,
    PH_Y0 = 2'd1,
    PH_CR = 2'd2,
    PH_Y1 = 2'd3
  } phase_t;

  localparam int          H_ACTIVE_DEF = 640;
  localparam int          V_ACTIVE_DEF = 480;
  localparam logic [7:0]  CHROMA_ZERO  = 8'd128;

endpackage

// File: rtl/ycbcr_capture_if.sv
// Camera byte bus in, reconstructed pixel stream out; master drives the camera side.
interface ycbcr_capture_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic          VSYNC;
  logic          HREF;
  logic [7:0]    D;
  logic          capture_en;
  logic          e_pix;
  logic [7:0]    Y;
  logic [7:0]    Cb;
  logic [7:0]    Cr;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          frame_start;
  logic          line_err;

  modport master (
    output VSYNC, HREF, D, capture_en,
    input  e_pix, Y, Cb, Cr, pix_x, pix_y, frame_start, line_err
  );

  modport slave (
    input  VSYNC, HREF, D, capture_en,
    output e_pix, Y, Cb, Cr, pix_x, pix_y, frame_start, line_err
  );
endinterface

// File: rtl/cam_sync_tracker.sv
// VSYNC/HREF edge tracking, frame arming, byte/line counting and the sticky line error.
module cam_sync_tracker #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          PCLK,
  input  logic          reset,
  input  logic          i_vsync,
  input  logic          i_href,
  input  logic          i_capture_en,
  output logic          o_active,
  output logic          o_href_fall,
  output logic [XW-2:0] o_pair,
  output logic [YW-1:0] o_line_cnt,
  output logic          o_line_err
);

  localparam logic [XW:0]   LINE_BYTES = (XW+1)'(2 * H_ACTIVE);
  localparam logic [YW-1:0] LINE_LAST  = YW'(V_ACTIVE - 1);

  logic          r_vsync_d;
  logic          r_href_d;
  logic          r_armed;
  logic          r_active;
  logic [XW:0]   r_byte_cnt;
  logic [YW-1:0] r_line_cnt;
  logic          r_line_err;
  logic          w_href_fall;

  assign w_href_fall = r_href_d & ~i_href;

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      r_vsync_d  <= 1'b0;
      r_href_d   <= 1'b0;
      r_armed    <= 1'b0;
      r_active   <= 1'b0;
      r_byte_cnt <= '0;
      r_line_cnt <= '0;
      r_line_err <= 1'b0;
    end else begin
      r_vsync_d <= i_vsync;
      r_href_d  <= i_href;
      if (i_vsync) begin
        r_armed    <= i_capture_en;
        r_byte_cnt <= '0;
        r_line_cnt <= '0;
        if (i_capture_en) r_line_err <= 1'b0;
      end else begin
        // capture_en is only honoured here, at the blanking-to-active transition
        if (r_vsync_d) r_active <= r_armed;
        if (r_active) begin
          if (w_href_fall) begin
            if (r_byte_cnt != LINE_BYTES) r_line_err <= 1'b1;
            r_byte_cnt <= '0;
            if (r_line_cnt != LINE_LAST) r_line_cnt <= r_line_cnt + 1'b1;
          end else if (i_href && (r_byte_cnt != '1)) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign o_active    = r_active;
  assign o_href_fall = w_href_fall;
  assign o_pair      = r_byte_cnt[XW:2];
  assign o_line_cnt  = r_line_cnt;
  assign o_line_err  = r_line_err;

endmodule

// File: rtl/ycbcr_capture.sv
// Rebuilds per-pixel Y/Cb/Cr from the Cb,Y0,Cr,Y1 byte stream and tags each pixel with x/y.
module ycbcr_capture
  import ycbcr_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input logic           PCLK,
  input logic           reset,
  ycbcr_capture_if.slave cam
);

  phase_t        r_phase;
  logic [7:0]    r_cb_hold;
  logic [7:0]    r_cr_hold;
  logic [7:0]    r_y0_hold;
  logic [7:0]    r_y1_hold;
  logic          r_pending;
  logic          r_e_pix;
  logic [7:0]    r_y;
  logic [7:0]    r_cb;
  logic [7:0]    r_cr;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;
  logic          r_frame_start;

  logic          w_active;
  logic          w_href_fall;
  logic [XW-2:0] w_pair;
  logic [YW-1:0] w_line_cnt;
  logic          w_line_err;

  cam_sync_tracker #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_sync (
    .PCLK         (PCLK),
    .reset        (reset),
    .i_vsync      (cam.VSYNC),
    .i_href       (cam.HREF),
    .i_capture_en (cam.capture_en),
    .o_active     (w_active),
    .o_href_fall  (w_href_fall),
    .o_pair       (w_pair),
    .o_line_cnt   (w_line_cnt),
    .o_line_err   (w_line_err)
  );

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      r_phase       <= PH_CB;
      r_cb_hold     <= '0;
      r_cr_hold     <= '0;
      r_y0_hold     <= '0;
      r_y1_hold     <= '0;
      r_pending     <= 1'b0;
      r_e_pix       <= 1'b0;
      r_y           <= '0;
      r_cb          <= '0;
      r_cr          <= '0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_e_pix       <= 1'b0;
      r_frame_start <= 1'b0;
      // Second pixel of a pair finishes unconditionally, even across HREF/VSYNC edges
      if (r_pending) begin
        r_y       <= r_y1_hold;
        r_pix_x   <= {r_pix_x[XW-1:1], 1'b1};
        r_e_pix   <= 1'b1;
        r_pending <= 1'b0;
      end
      if (cam.VSYNC) begin
        r_phase   <= PH_CB;
        r_pending <= 1'b0;
      end else if (w_href_fall) begin
        r_phase <= PH_CB;
      end else if (cam.HREF && w_active) begin
        unique case (r_phase)
          PH_CB: begin
            r_cb_hold <= cam.D;
            r_phase   <= PH_Y0;
          end
          PH_Y0: begin
            r_y0_hold <= cam.D;
            r_phase   <= PH_CR;
          end
          PH_CR: begin
            r_cr_hold <= cam.D;
            r_phase   <= PH_Y1;
          end
          PH_Y1: begin
            r_y           <= r_y0_hold;
            r_cb          <= r_cb_hold;
            r_cr          <= r_cr_hold;
            r_e_pix       <= 1'b1;
            r_pix_x       <= {w_pair, 1'b0};
            r_pix_y       <= w_line_cnt;
            r_frame_start <= (w_pair == '0) && (w_line_cnt == '0);
            r_y1_hold     <= cam.D;
            r_pending     <= 1'b1;
            r_phase       <= PH_CB;
          end
          default: r_phase <= PH_CB;
        endcase
      end
    end
  end

  assign cam.e_pix       = r_e_pix;
  assign cam.Y           = r_y;
  assign cam.Cb          = r_cb;
  assign cam.Cr          = r_cr;
  assign cam.pix_x       = r_pix_x;
  assign cam.pix_y       = r_pix_y;
  assign cam.frame_start = r_frame_start;
  assign cam.line_err    = w_line_err;

endmodule
